mem_stage_dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage, directly upstream of the MEM/WB pipeline register.
- Serves CPU load/store word accesses and drives the pipeline stall that freezes MEM/WB and earlier stages on a miss.
- Its read data is the memory-data operand latched into MEM/WB.
- Talks to a 256-bit-line off-chip data memory through an enable/ack handshake.

---
 rtl/mem_stage_dcache.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_dcache.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Serves word loads/stores combinationally on a hit and stalls the pipeline
// while a 256-bit line is written back and/or fetched over an enable/ack port.
module mem_stage_dcache #(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_req_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned TAG_BITS  = 32 - 5 - INDEX_BITS;
  localparam int unsigned LINES     = 1 << INDEX_BITS;
  localparam int unsigned LINE_BITS = 256;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILLED} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;

  logic                 mem_enable_q, mem_enable_d;
  logic                 mem_write_q, mem_write_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

  logic [2:0]            word_c;
  logic [7:0]            wbit_c;
  logic [INDEX_BITS-1:0] idx_c;
  logic [TAG_BITS-1:0]   tag_c;
  logic                  hit_c;
  logic                  fill_c;
  logic                  store_hit_c;
  logic [31:0]           rd_word_c;
  logic                  unused_addr_c;

  // Request address decode and hit detection
  assign word_c        = p1_addr_i[4:2];
  assign wbit_c        = {word_c, 5'b0};
  assign idx_c         = p1_addr_i[INDEX_BITS+4:5];
  assign tag_c         = p1_addr_i[31:INDEX_BITS+5];
  assign unused_addr_c = ^p1_addr_i[1:0];
  assign hit_c         = p1_req_i & valid_q[idx_c] & (tag_q[idx_c] == tag_c);
  assign rd_word_c     = data_q[idx_c][wbit_c +: 32];
  assign fill_c        = (state_q == FETCH) & mem_ack_i;
  assign store_hit_c   = (state_q == IDLE) & hit_c & p1_write_i;

  // Pipeline-facing outputs are combinational so a hit costs no cycles
  assign p1_data_o  = (hit_c & ~p1_write_i) ? rd_word_c : 32'h0;
  assign p1_stall_o = (state_q != IDLE) | (p1_req_i & ~hit_c);

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // Next state and next memory-port values; mem_* hold steady until ack
  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = 32'h0;
    mem_data_d   = '0;
    case (state_q)
      IDLE: begin
        if (p1_req_i && !hit_c) begin
          miss_tag_d   = tag_c;
          miss_idx_d   = idx_c;
          mem_enable_d = 1'b1;
          if (valid_q[idx_c] && dirty_q[idx_c]) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx_c], idx_c, 5'b0};
            mem_data_d  = data_q[idx_c];
          end else begin
            state_d    = FETCH;
            mem_addr_d = {tag_c, idx_c, 5'b0};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d      = FETCH;
          mem_enable_d = 1'b1;
          mem_addr_d   = {miss_tag_q, miss_idx_q, 5'b0};
        end else begin
          mem_enable_d = mem_enable_q;
          mem_write_d  = mem_write_q;
          mem_addr_d   = mem_addr_q;
          mem_data_d   = mem_data_q;
        end
      end
      FETCH: begin
        if (mem_ack_i) begin
          state_d = FILLED;
        end else begin
          mem_enable_d = mem_enable_q;
          mem_write_d  = mem_write_q;
          mem_addr_d   = mem_addr_q;
          mem_data_d   = mem_data_q;
        end
      end
      FILLED: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, miss latches and registered memory port
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Line valid/dirty flags; reset invalidates the whole cache
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_c) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (store_hit_c) begin
      dirty_q[idx_c] <= 1'b1;
    end
  end

  // Tag and data arrays: line install on fill, word update on store hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (fill_c) begin
        data_q[miss_idx_q] <= mem_data_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end else if (store_hit_c) begin
        data_q[idx_c][wbit_c +: 32] <= p1_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: a line-level memory responder
// with fixed ack latency, an architectural word-level reference memory, and
// queues of expected load data and expected memory transactions.
module tb_mem_stage_dcache;

  localparam int LAT = 3;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    bit          chk;
    int          w;
    logic [31:0] word;
  } mreq_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         p1_req_i = 1'b0;
  logic         p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = 32'h0;
  logic [31:0]  p1_data_i = 32'h0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  bit mem_hold  = 1'b0;
  bit stray_req = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mreq_t       mem_exp[$];
  logic [31:0] ld_exp[$];
  logic [31:0] mem_words[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  always #5 clk = ~clk;

  mem_stage_dcache dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : init_word(a);
  endfunction

  function automatic mreq_t mk(input bit wr, input logic [31:0] a, input bit chk,
                               input int w, input logic [31:0] word);
    mreq_t e;
    e.wr = wr; e.addr = a; e.chk = chk; e.w = w; e.word = word;
    return e;
  endfunction

  // Off-chip memory: acks LAT cycles after a request is seen, checks it in order
  initial begin : responder
    int          cnt;
    mreq_t       e;
    logic [255:0] line;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = (mem_enable_o && !mem_hold) ? 1 : 0;
      end else if (stray_req) begin
        stray_req  = 1'b0;
        mem_data_i = '1;
        mem_ack_i  = 1'b1;
      end else if (mem_enable_o && !mem_hold) begin
        cnt++;
        if (cnt >= LAT) begin
          n_tests++;
          if (mem_exp.size() == 0) begin
            n_fail++;
            $display("FAIL mem_req: got wr=%0b addr=%h, required no request", mem_write_o, mem_addr_o);
          end else begin
            e = mem_exp.pop_front();
            if (mem_write_o !== e.wr || mem_addr_o !== e.addr) begin
              n_fail++;
              $display("FAIL mem_req: got wr=%0b addr=%h, required wr=%0b addr=%h",
                       mem_write_o, mem_addr_o, e.wr, e.addr);
            end
            if (e.chk) begin
              n_tests++;
              if (mem_data_o[32*e.w +: 32] !== e.word) begin
                n_fail++;
                $display("FAIL wb_data: got word%0d=%h, required %h", e.w, mem_data_o[32*e.w +: 32], e.word);
              end
            end
          end
          if (mem_write_o) begin
            for (int w = 0; w < 8; w++) mem_words[mem_addr_o + 32'(4*w)] = mem_data_o[32*w +: 32];
          end else begin
            for (int w = 0; w < 8; w++) line[32*w +: 32] = mem_word(mem_addr_o + 32'(4*w));
            mem_data_i = line;
          end
          mem_ack_i = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  // Present one access and wait (bounded) for the stall to clear
  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int cyc, output logic [31:0] got);
    @(negedge clk);
    p1_req_i   = 1'b1;
    p1_write_i = wr;
    p1_addr_i  = a;
    p1_data_i  = d;
    if (wr) begin
      ref_mem[{a[31:2], 2'b00}] = d;
      ld_exp.push_back(32'h0);
    end else begin
      ld_exp.push_back(ref_word(a));
    end
    #1;
    cyc = 0;
    while (p1_stall_o !== 1'b0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    got = p1_data_o;
  endtask

  task automatic go_idle();
    @(negedge clk);
    p1_req_i   = 1'b0;
    p1_write_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    p1_req_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests += 5;
    if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", p1_stall_o); end
    if (p1_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", p1_data_o); end
    if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b, required 0", mem_enable_o); end
    if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b, required 0", mem_write_o); end
    if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", mem_addr_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_load_miss();
    logic [31:0] ad [2] = '{32'h40, 32'h48};
    int          st [2] = '{LAT + 2, 0};
    int          cyc;
    logic [31:0] got, exp;
    mem_words[32'h48] = 32'hDEAD_BEEF;
    ref_mem[32'h48]   = 32'hDEAD_BEEF;
    mem_exp.push_back(mk(1'b0, 32'h40, 1'b0, 0, 32'h0));
    for (int i = 0; i < 2; i++) begin
      do_access(1'b0, ad[i], 32'h0, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != st[i]) begin n_fail++; $display("FAIL load_miss_stall[%0d]: got %0d cycles, required %0d", i, cyc, st[i]); end
      if (got !== exp) begin n_fail++; $display("FAIL load_miss_data[%0d]: got %h, required %h", i, got, exp); end
    end
  endtask

  task automatic test_store_hit();
    logic        wr [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ad [3] = '{32'h48, 32'h48, 32'h40};
    int          cyc;
    logic [31:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      do_access(wr[i], ad[i], 32'h1234_5678, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != 0) begin n_fail++; $display("FAIL store_hit_stall[%0d]: got %0d cycles, required 0", i, cyc); end
      if (got !== exp) begin n_fail++; $display("FAIL store_hit_data[%0d]: got %h, required %h", i, got, exp); end
    end
    go_idle();
  endtask

  task automatic test_writeback();
    logic [31:0] ad [3] = '{32'h448, 32'h448, 32'h48};
    int          st [3] = '{2*LAT + 2, 0, LAT + 2};
    int          cyc;
    logic [31:0] got, exp;
    mem_exp.push_back(mk(1'b1, 32'h40, 1'b1, 2, 32'h1234_5678));
    mem_exp.push_back(mk(1'b0, 32'h440, 1'b0, 0, 32'h0));
    mem_exp.push_back(mk(1'b0, 32'h40, 1'b0, 0, 32'h0));
    for (int i = 0; i < 3; i++) begin
      do_access(1'b0, ad[i], 32'h0, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != st[i]) begin n_fail++; $display("FAIL writeback_stall[%0d]: got %0d cycles, required %0d", i, cyc, st[i]); end
      if (got !== exp) begin n_fail++; $display("FAIL writeback_data[%0d]: got %h, required %h", i, got, exp); end
    end
    go_idle();
  endtask

  task automatic test_store_miss();
    logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad [4] = '{32'h84, 32'h84, 32'h484, 32'h84};
    int          st [4] = '{LAT + 2, 0, 2*LAT + 2, LAT + 2};
    int          cyc;
    logic [31:0] got, exp;
    mem_exp.push_back(mk(1'b0, 32'h80, 1'b0, 0, 32'h0));
    mem_exp.push_back(mk(1'b1, 32'h80, 1'b1, 1, 32'hCAFE_F00D));
    mem_exp.push_back(mk(1'b0, 32'h480, 1'b0, 0, 32'h0));
    mem_exp.push_back(mk(1'b0, 32'h80, 1'b0, 0, 32'h0));
    for (int i = 0; i < 4; i++) begin
      do_access(wr[i], ad[i], 32'hCAFE_F00D, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != st[i]) begin n_fail++; $display("FAIL store_miss_stall[%0d]: got %0d cycles, required %0d", i, cyc, st[i]); end
      if (got !== exp) begin n_fail++; $display("FAIL store_miss_data[%0d]: got %h, required %h", i, got, exp); end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_fetch();
    int          cyc;
    logic [31:0] got, exp;
    mem_hold = 1'b1;
    @(negedge clk);
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'hC0;
    #1;
    n_tests++;
    if (p1_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_stall: got %b, required 1", p1_stall_o); end
    repeat (3) @(negedge clk);
    #1;
    n_tests += 2;
    if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_enable: got %b, required 1", mem_enable_o); end
    if (mem_addr_o !== 32'hC0) begin n_fail++; $display("FAIL rst_fetch_addr: got %h, required c0", mem_addr_o); end
    @(negedge clk);
    rst_i = 1'b0; p1_req_i = 1'b0;
    @(negedge clk);
    #1;
    n_tests += 3;
    if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL rst_abort_enable: got %b, required 0", mem_enable_o); end
    if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_abort_stall: got %b, required 0", p1_stall_o); end
    if (p1_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_abort_data: got %h, required 0", p1_data_o); end
    rst_i = 1'b1;
    mem_hold = 1'b0;
    mem_exp.push_back(mk(1'b0, 32'h80, 1'b0, 0, 32'h0));
    do_access(1'b0, 32'h84, 32'h0, cyc, got);
    exp = ld_exp.pop_front();
    n_tests += 2;
    if (cyc != LAT + 2) begin n_fail++; $display("FAIL rst_remiss_stall: got %0d cycles, required %0d", cyc, LAT + 2); end
    if (got !== exp) begin n_fail++; $display("FAIL rst_remiss_data: got %h, required %h", got, exp); end
    go_idle();
  endtask

  task automatic test_stray_ack();
    logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [4] = '{32'h84, 32'h88, 32'h88, 32'h84};
    int          cyc;
    logic [31:0] got, exp;
    stray_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_access(wr[i], ad[i], 32'h55AA_55AA, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != 0) begin n_fail++; $display("FAIL stray_stall[%0d]: got %0d cycles, required 0", i, cyc); end
      if (got !== exp) begin n_fail++; $display("FAIL stray_data[%0d]: got %h, required %h", i, got, exp); end
    end
    go_idle();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL stray_enable: got %b, required 0", mem_enable_o); end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] got, exp, a;
    logic        wr;
    for (int i = 0; i < 12; i++) begin
      a  = 32'h80 + 32'(4 * $urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      do_access(wr, a, $urandom, cyc, got);
      exp = ld_exp.pop_front();
      n_tests += 2;
      if (cyc != 0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0d cycles, required 0", i, cyc); end
      if (got !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, got, exp); end
    end
    go_idle();
  endtask

  task automatic test_drain();
    repeat (LAT + 2) @(negedge clk);
    n_tests++;
    if (mem_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain_mem: got %0d pending requests, required 0", mem_exp.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_writeback();
    test_store_miss();
    test_reset_mid_fetch();
    test_stray_ack();
    test_back_to_back();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
